// File: rtl/call_stack_sequencer_pkg.sv
// Shared types and constants for the subroutine-linkage stack sequencer:
// command opcodes, FSM state encodings and the stack page location.
package call_stack_sequencer_pkg;

    localparam int RAM_ADDR_WIDTH = 12;
    localparam int SP_WIDTH       = 8;
    localparam int PC_WIDTH       = 13;

    localparam logic [3:0] STACK_PAGE = 4'h0;

    typedef enum logic [1:0] {
        PUSH_PC     = 2'd0,
        POP_PC      = 2'd1,
        POP_PC_SKIP = 2'd2,
        RSVD        = 2'd3
    } stack_op_t;

    // Plain encoded constants keep the state vector readable in older tools.
    typedef logic [3:0] stack_state_t;

    localparam stack_state_t ST_IDLE = 4'd0;
    localparam stack_state_t ST_W_P  = 4'd1;
    localparam stack_state_t ST_W_H  = 4'd2;
    localparam stack_state_t ST_W_L  = 4'd3;
    localparam stack_state_t ST_R_L  = 4'd4;
    localparam stack_state_t ST_R_H  = 4'd5;
    localparam stack_state_t ST_R_P  = 4'd6;
    localparam stack_state_t ST_CAP  = 4'd7;
    localparam stack_state_t ST_FIN  = 4'd8;

    // The page bit (bit 12) never takes part in the return-address increment.
    function automatic logic [11:0] inc12(input logic [11:0] v);
        return v + 12'd1;
    endfunction

endpackage

// File: rtl/call_stack_sequencer_if.sv
// Decode-side command bus, shared data-RAM port and PC/SP writeback of the
// stack sequencer, bundled as one interface.
interface call_stack_sequencer_if;
    import call_stack_sequencer_pkg::*;

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [1:0]                cmd_op;
    logic [PC_WIDTH-1:0]       pc_in;
    logic [PC_WIDTH-1:0]       pc_target;
    logic [SP_WIDTH-1:0]       sp_in;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [3:0]                ram_wdata;
    logic                      ram_we;
    logic [3:0]                ram_rdata;
    logic [PC_WIDTH-1:0]       pc_out;
    logic                      pc_we;
    logic [SP_WIDTH-1:0]       sp_out;
    logic                      sp_we;
    logic                      done;
    logic                      busy;

    modport master (
        output cmd_valid, cmd_op, pc_in, pc_target, sp_in, ram_rdata,
        input  cmd_ready, ram_addr, ram_wdata, ram_we, pc_out, pc_we,
               sp_out, sp_we, done, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, pc_in, pc_target, sp_in, ram_rdata,
        output cmd_ready, ram_addr, ram_wdata, ram_we, pc_out, pc_we,
               sp_out, sp_we, done, busy
    );

endinterface

// File: rtl/call_stack_sequencer.sv
// Stack micro-sequencer: pushes the return address for CALL/CALZ and pops it
// for RET/RETS over the shared nibble RAM port, then writes back SP and PC.
module call_stack_sequencer
    import call_stack_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_en,
    call_stack_sequencer_if.slave bus
);

    stack_state_t        state_q;
    stack_state_t        state_d;
    stack_op_t           op_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] target_q;
    logic [SP_WIDTH-1:0] sp_q;
    logic [3:0]          l_q;
    logic [3:0]          h_q;
    logic [3:0]          p_q;

    logic [11:0]         ret_addr;
    logic [11:0]         popped;
    logic [SP_WIDTH-1:0] addr_lo;
    logic                we_st;
    logic                upd_st;
    logic                done_st;

    assign ret_addr = inc12(pc_q[11:0]);
    assign popped   = {p_q, h_q, l_q};

    // NOTE: every variable assigned in always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    case (stack_op_t'(bus.cmd_op))
                        PUSH_PC:             state_d = ST_W_P;
                        POP_PC, POP_PC_SKIP: state_d = ST_R_L;
                        default:             state_d = ST_FIN;
                    endcase
                end
            end
            ST_W_P:  state_d = ST_W_H;
            ST_W_H:  state_d = ST_W_L;
            ST_W_L:  state_d = ST_FIN;
            ST_R_L:  state_d = ST_R_H;
            ST_R_H:  state_d = ST_R_P;
            ST_R_P:  state_d = ST_CAP;
            ST_CAP:  state_d = ST_FIN;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values; the few datapath registers are reset too,
    // which keeps outputs deterministic right after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= PUSH_PC;
            pc_q     <= '0;
            target_q <= '0;
            sp_q     <= '0;
            l_q      <= '0;
            h_q      <= '0;
            p_q      <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.cmd_valid) begin
                op_q     <= stack_op_t'(bus.cmd_op);
                pc_q     <= bus.pc_in;
                target_q <= bus.pc_target;
                sp_q     <= bus.sp_in;
            end
            // Read data trails the address by one step.
            if (state_q == ST_R_H) l_q <= bus.ram_rdata;
            if (state_q == ST_R_P) h_q <= bus.ram_rdata;
            if (state_q == ST_CAP) p_q <= bus.ram_rdata;
        end
    end

    always_comb begin
        addr_lo       = '0;
        bus.ram_wdata = '0;
        bus.pc_out    = '0;
        bus.sp_out    = '0;
        we_st         = 1'b0;
        upd_st        = 1'b0;
        done_st       = 1'b0;
        case (state_q)
            ST_W_P: begin
                addr_lo       = sp_q - SP_WIDTH'(1);
                bus.ram_wdata = ret_addr[11:8];
                we_st         = 1'b1;
            end
            ST_W_H: begin
                addr_lo       = sp_q - SP_WIDTH'(2);
                bus.ram_wdata = ret_addr[7:4];
                we_st         = 1'b1;
            end
            ST_W_L: begin
                addr_lo       = sp_q - SP_WIDTH'(3);
                bus.ram_wdata = ret_addr[3:0];
                we_st         = 1'b1;
            end
            ST_R_L: addr_lo = sp_q;
            ST_R_H: addr_lo = sp_q + SP_WIDTH'(1);
            ST_R_P: addr_lo = sp_q + SP_WIDTH'(2);
            ST_FIN: begin
                done_st = 1'b1;
                case (op_q)
                    PUSH_PC: begin
                        bus.sp_out = sp_q - SP_WIDTH'(3);
                        bus.pc_out = target_q;
                        upd_st     = 1'b1;
                    end
                    POP_PC: begin
                        bus.sp_out = sp_q + SP_WIDTH'(3);
                        bus.pc_out = {pc_q[12], popped};
                        upd_st     = 1'b1;
                    end
                    POP_PC_SKIP: begin
                        bus.sp_out = sp_q + SP_WIDTH'(3);
                        bus.pc_out = {pc_q[12], inc12(popped)};
                        upd_st     = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Strobes are qualified by clk_en so a stalled step never repeats them.
    assign bus.ram_addr  = {STACK_PAGE, addr_lo};
    assign bus.ram_we    = we_st & clk_en;
    assign bus.pc_we     = upd_st & clk_en;
    assign bus.sp_we     = upd_st & clk_en;
    assign bus.done      = done_st & clk_en;
    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);

endmodule
